// File: rtl/key_unlock_loader.sv
// Serial key provisioning front end: receives a framed, parity-protected unlock key and drives
// the key bus of a logic-locked core, with a decoy key and a permanent brute-force lockout.
module key_unlock_loader #(
  parameter int unsigned      KEY_W    = 10,
  parameter logic [KEY_W-1:0] DECOY    = '0,
  parameter int unsigned      MAX_FAIL = 3,
  parameter int unsigned      TIMEOUT  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              sdi,
  input  logic                              sdi_vld,
  output logic                              busy,
  output logic [KEY_W-1:0]                  key_out,
  output logic                              key_ok,
  output logic                              fail,
  output logic                              lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int unsigned FCW = $clog2(MAX_FAIL + 1);
  localparam int unsigned BCW = $clog2(KEY_W + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  localparam logic [FCW-1:0] MaxFailC = FCW'(MAX_FAIL);
  localparam logic [BCW-1:0] LastBit  = BCW'(KEY_W - 1);
  localparam logic [TCW-1:0] TmoLast  = TCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StShift, StPar, StCheck, StLock} state_e;

  state_e           state_q;
  logic [KEY_W-1:0] shreg_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [TCW-1:0]   tmo_cnt_q;
  logic             par_q;

  logic [FCW-1:0]   fail_cnt_inc;
  logic             fail_locks;
  logic             parity_good;

  // Saturating increment; reaching MAX_FAIL on a bad frame is what sends us to lockout.
  assign fail_cnt_inc = (fail_cnt == MaxFailC) ? fail_cnt : fail_cnt + FCW'(1);
  assign fail_locks   = (fail_cnt_inc == MaxFailC);
  assign parity_good  = ~^{shreg_q, par_q};

  assign busy    = (state_q == StShift) || (state_q == StPar) || (state_q == StCheck);
  assign lockout = (state_q == StLock);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tmo_cnt_q <= '0;
      par_q     <= 1'b0;
      key_out   <= DECOY;
      key_ok    <= 1'b0;
      fail      <= 1'b0;
      fail_cnt  <= '0;
    end else begin
      fail <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StShift;
            key_out   <= DECOY;
            key_ok    <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
          end
        end
        StShift, StPar: begin
          if (start) begin
            // Restart: drop the partial frame, any beat in this cycle is discarded.
            state_q   <= StShift;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
          end else if (sdi_vld) begin
            tmo_cnt_q <= '0;
            if (state_q == StShift) begin
              shreg_q   <= {shreg_q[KEY_W-2:0], sdi};
              bit_cnt_q <= bit_cnt_q + BCW'(1);
              if (bit_cnt_q == LastBit) state_q <= StPar;
            end else begin
              par_q   <= sdi;
              state_q <= StCheck;
            end
          end else if (tmo_cnt_q == TmoLast) begin
            fail     <= 1'b1;
            fail_cnt <= fail_cnt_inc;
            state_q  <= fail_locks ? StLock : StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TCW'(1);
          end
        end
        StCheck: begin
          if (parity_good) begin
            key_out  <= shreg_q;
            key_ok   <= 1'b1;
            fail_cnt <= '0;
            state_q  <= StIdle;
          end else begin
            fail     <= 1'b1;
            fail_cnt <= fail_cnt_inc;
            state_q  <= fail_locks ? StLock : StIdle;
          end
        end
        StLock: begin
          key_out <= DECOY;
          key_ok  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_key_unlock_loader.sv
// Self-checking bench for key_unlock_loader: directed scenarios then randomized frames,
// checked against a frame-level model of key, failure count and lockout.
module tb_key_unlock_loader;

  localparam int unsigned      KEY_W    = 10;
  localparam int unsigned      MAX_FAIL = 3;
  localparam int unsigned      TIMEOUT  = 16;
  localparam logic [KEY_W-1:0] DECOY    = '0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sdi = 1'b0;
  logic             sdi_vld = 1'b0;
  logic             busy, key_ok, fail, lockout;
  logic [KEY_W-1:0] key_out;
  logic [1:0]       fail_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Frame-level reference model
  int               m_fcnt;
  bit               m_locked;
  bit               m_ok;
  logic [KEY_W-1:0] m_key;

  key_unlock_loader #(
    .KEY_W    (KEY_W),
    .DECOY    (DECOY),
    .MAX_FAIL (MAX_FAIL),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sdi      (sdi),
    .sdi_vld  (sdi_vld),
    .busy     (busy),
    .key_out  (key_out),
    .key_ok   (key_ok),
    .fail     (fail),
    .lockout  (lockout),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_bad();
    m_fcnt = (m_fcnt + 1 > int'(MAX_FAIL)) ? int'(MAX_FAIL) : m_fcnt + 1;
    if (m_fcnt == int'(MAX_FAIL)) m_locked = 1'b1;
    m_key = DECOY;
    m_ok  = 1'b0;
  endtask

  task automatic check_outs(input bit exp_fail);
    check("fail", fail, exp_fail);
    check("key_out", key_out, m_locked ? DECOY : m_key);
    check("key_ok", key_ok, m_locked ? 1'b0 : m_ok);
    check("fail_cnt", fail_cnt, m_fcnt);
    check("lockout", lockout, m_locked);
    check("busy_idle", busy, 0);
  endtask

  task automatic beat(input logic b, input int gap);
    sdi_vld = 1'b0;
    repeat (gap) cyc();
    sdi     = b;
    sdi_vld = 1'b1;
    cyc();
    sdi_vld = 1'b0;
    sdi     = 1'($urandom);
  endtask

  // Start pulse, sometimes with a coincident beat that must be dropped.
  task automatic do_start();
    start   = 1'b1;
    sdi_vld = 1'($urandom_range(0, 1));
    sdi     = 1'($urandom);
    cyc();
    start   = 1'b0;
    sdi_vld = 1'b0;
    if (!m_locked) begin
      m_key = DECOY;
      m_ok  = 1'b0;
    end
    check("start_busy", busy, !m_locked);
    check("start_key_ok", key_ok, 0);
    check("start_key_out", key_out, DECOY);
    check("start_fail_cnt", fail_cnt, m_fcnt);
    check("start_lockout", lockout, m_locked);
  endtask

  task automatic frame(input logic [KEY_W-1:0] k, input bit good, input int gmax);
    logic par;
    par = (^k) ^ !good;
    do_start();
    for (int i = KEY_W - 1; i >= 0; i--) beat(k[i], $urandom_range(0, gmax));
    beat(par, $urandom_range(0, gmax));
    if (m_locked) begin
      cyc();
      check_outs(0);
      return;
    end
    check("check_busy", busy, 1);
    check("check_key_ok", key_ok, 0);
    cyc();
    if (good) begin
      m_key  = k;
      m_ok   = 1'b1;
      m_fcnt = 0;
    end else begin
      model_bad();
    end
    check_outs(!good);
    cyc();
    check("fail_single_cycle", fail, 0);
  endtask

  task automatic tmo_frame(input int n);
    do_start();
    for (int i = 0; i < n; i++) beat(1'($urandom), $urandom_range(0, 3));
    if (m_locked) begin
      repeat (TIMEOUT) cyc();
      check_outs(0);
      return;
    end
    repeat (TIMEOUT - 1) cyc();
    check("tmo_wait_busy", busy, 1);
    check("tmo_wait_fail", fail, 0);
    cyc();
    model_bad();
    check_outs(1);
    cyc();
    check("tmo_fail_single_cycle", fail, 0);
  endtask

  task automatic restart_frame(input int m, input logic [KEY_W-1:0] k, input bit good);
    do_start();
    for (int i = 0; i < m; i++) beat(1'($urandom), $urandom_range(0, 2));
    frame(k, good, 2);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_fcnt   = 0;
    m_locked = 1'b0;
    m_ok     = 1'b0;
    m_key    = DECOY;
    check("rst_key_out", key_out, DECOY);
    check("rst_key_ok", key_ok, 0);
    check("rst_lockout", lockout, 0);
    check("rst_busy", busy, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    m_fcnt   = 0;
    m_locked = 1'b0;
    m_ok     = 1'b0;
    m_key    = DECOY;
    repeat (2) @(posedge clk);
    #1;
    check("reset_key_out", key_out, DECOY);
    check("reset_key_ok", key_ok, 0);
    check("reset_fail", fail, 0);
    check("reset_lockout", lockout, 0);
    check("reset_busy", busy, 0);
    check("reset_fail_cnt", fail_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Good frame 1011001110, even parity bit 0
    frame(10'h2CE, 1'b1, 0);
    check("good_key_value", key_out, 10'h2CE);
    // Same key, wrong parity, then two more to reach lockout
    frame(10'h2CE, 1'b0, 1);
    frame(10'h155, 1'b0, 2);
    frame(10'h0F0, 1'b0, 0);
    check("locked_after_three", lockout, 1);
    frame(10'h2CE, 1'b1, 0);
    do_reset();
    // Timeout after 4 beats
    tmo_frame(4);
    // Restart mid-frame, fail count survives the restart
    restart_frame(6, 10'h3A5, 1'b1);
    // Reset in the middle of a frame following a valid key
    frame(10'h1C3, 1'b1, 1);
    do_start();
    for (int i = 0; i < 5; i++) beat(1'($urandom), 0);
    do_reset();
    frame(10'h2CE, 1'b1, 1);

    for (int it = 0; it < 40; it++) begin
      int               sel;
      logic [KEY_W-1:0] k;
      sel = $urandom_range(0, 9);
      k   = KEY_W'($urandom);
      if (sel < 6) frame(k, $urandom_range(0, 9) < 6, 3);
      else if (sel < 8) tmo_frame($urandom_range(0, KEY_W));
      else if (sel == 8) restart_frame($urandom_range(0, KEY_W), k, 1'($urandom));
      else do_reset();
      if (m_locked && ($urandom_range(0, 2) == 0)) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
